product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of the team's 4-bit gate-level array multiplier.
- Consumes its 8-bit products through a valid/ready stream and accumulates a burst of products into a wide sum (dot-product / MAC datapath).
- Terminates the burst on an in_last marker or on a maximum term count, then holds the result on an output valid/ready port.
- The multiplier stays purely combinational; this block supplies the registers, control FSM and handshakes.

Parameters:
- ACC_W, 12, accumulator and out_sum width in bits (must be ≥ 8).
- CNT_W, 5, term-counter width; the maximum burst length is 2^CNT_W − 1 terms (31 by default).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_prod/in_last are valid this cycle.
- in_ready  output  1  block can accept a term this cycle.
- in_prod  input  8  unsigned product from the multiplier.
- in_last  input  1  marks the final term of a burst.
- out_valid  output  1  out_* hold a completed burst result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_count  output  CNT_W  number of terms in the burst.
- out_ovf  output  1  sum carried out of ACC_W bits at least once during the burst.
- out_trunc  output  1  burst was closed by count saturation, not by in_last.

Behaviour:
- Reset: while rst_n = 0, asynchronously
  - FSM → ACC;
  - acc = 0, count = 0, ovf = 0, trunc = 0;
  - out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0, out_trunc = 0.
  - Release is synchronous to the next clk edge. Reset mid-burst discards all partial state; no result is emitted.
- All outputs are registered. in_ready is decoded from state only: in_ready = (state == ACC). It never depends combinationally on in_valid or out_ready.
- An input beat is accepted when in_valid & in_ready at a rising clk edge.
- FSM states:
  - ACC: accept terms.
  - HOLD: present the result.
- ACC, accepted beat:
  - {carry, acc} ← acc + in_prod, with in_prod zero-extended to ACC_W+1 bits.
  - ovf ← ovf | carry.
  - count ← count + 1.
  - close = in_last | (count == 2^CNT_W − 2), i.e. the new count reaches the maximum.
  - If close:
    - out_sum ← new acc, out_count ← new count;
    - out_ovf ← new ovf, out_trunc ← ~in_last;
    - out_valid ← 1, state → HOLD;
    - acc, count, ovf cleared to 0 in the same edge.
  - If in_last coincides with saturation, out_trunc = 0.
- ACC, no beat: state unchanged. in_valid may toggle freely; no term is lost or duplicated.
- HOLD:
  - in_ready = 0; out_* stay stable.
  - On out_valid & out_ready: out_valid ← 0, state → ACC. out_sum, out_count, out_ovf and out_trunc retain their last values.
  - No bypass: the first term of the next burst is accepted at the earliest one cycle after the output handshake.
- Latency: out_valid rises on the edge that accepts the closing term. Throughput is one term per cycle within a burst, with ≥1 bubble cycle per burst for the output handshake.
- Zero-length bursts do not exist; every result has out_count ≥ 1.
- The input side must hold in_prod/in_last stable while in_valid & ~in_ready (standard valid/ready). The block tolerates any in_valid pattern.

Test Plan:
- Reset/idle: hold rst_n = 0 with random inputs → all outputs 0 and in_ready = 0 during reset. After release: in_ready = 1, out_valid = 0.
- Basic burst: products 225, 100, 6, with in_last on the 3rd → out_valid the cycle after the 3rd beat, with out_sum = 331, out_count = 3, out_ovf = 0, out_trunc = 0. in_ready = 0 until out_ready is pulsed.
- Backpressure: hold out_ready = 0 for 10 cycles after a result, driving in_valid = 1 → no beats accepted, out_* stable. Pulse out_ready → in_ready returns 1 the next cycle.
- Overflow and saturation: 31 beats of 225, in_last never set → close after the 31st beat with out_count = 31, out_sum = 6975 mod 4096 = 2879, out_ovf = 1, out_trunc = 1.
- Simultaneous close: in_last on exactly the 31st beat → out_trunc = 0, out_count = 31.
- Mid-burst reset: assert rst_n = 0 asynchronously (between edges) after 2 beats → outputs clear immediately. A subsequent burst of 15 and 15 with in_last gives out_sum = 30, out_count = 2.

Source files
------------

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sequential stage behind the 4-bit array multiplier. It sums a burst of 8-bit
// unsigned products arriving over a valid/ready stream. A burst ends when a
// beat arrives with in_last set, or when the term count reaches 2^CNT_W-1.
// The result is then held on a registered valid/ready output port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_prod / in_last valid this cycle
//   in_ready   block accepts a term this cycle (registered, state decoded)
//   in_prod    unsigned product from the multiplier
//   in_last    final term of the burst
//   out_valid  out_* hold a completed burst result
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum modulo 2^ACC_W
//   out_count  number of terms in the burst
//   out_ovf    sum carried out of ACC_W bits at least once in the burst
//   out_trunc  burst closed by count saturation rather than in_last
//
// state | meaning
// ------+-----------------------------------------------
// ACC   | accepting terms into acc/count/ovf
// HOLD  | result presented on out_*, waiting for out_ready
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_trunc
);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Count value just before the last permitted term (2^CNT_W - 2).
    localparam logic [CNT_W-1:0] CNT_PRE_SAT = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t             state;
    state_t             next_state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               ovf;

    logic               beat;
    logic               close;
    logic [ACC_W:0]     sum_ext;
    logic [CNT_W-1:0]   count_inc;
    logic               ovf_next;

    always_comb begin
        beat       = 1'b0;
        close      = 1'b0;
        sum_ext    = {1'b0, acc} + (ACC_W+1)'(in_prod);
        count_inc  = count + 1'b1;
        ovf_next   = ovf | sum_ext[ACC_W];
        next_state = state;

        case (state)
            ACC: begin
                // in_ready is a registered copy of (state == ACC); it is only
                // low here during the first cycle after reset release.
                beat  = in_valid & in_ready;
                close = beat & (in_last | (count == CNT_PRE_SAT));
                if (close) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = ACC;
                end
            end
            default: next_state = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            in_ready  <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == ACC);

            if (beat) begin
                if (close) begin
                    out_sum   <= sum_ext[ACC_W-1:0];
                    out_count <= count_inc;
                    out_ovf   <= ovf_next;
                    out_trunc <= ~in_last;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc   <= sum_ext[ACC_W-1:0];
                    count <= count_inc;
                    ovf   <= ovf_next;
                end
            end

            // Result fields keep their values after the handshake.
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        out_ovf;
    logic        out_trunc;

    int n_cmp;
    int n_err;

    product_accumulator #(.ACC_W(12), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input int sum, input int cnt,
                              input int ovf, input int trunc);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"},   32'(out_sum),   32'(sum));
        chk({tag, ".count"}, 32'(out_count), 32'(cnt));
        chk({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
        chk({tag, ".trunc"}, 32'(out_trunc), 32'(trunc));
        chk({tag, ".ready"}, 32'(in_ready),  32'd0);
    endtask

    task automatic handshake(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".hs_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset with random inputs: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_prod   = 8'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            step();
            chk("rst.in_ready",  32'(in_ready),  32'd0);
            chk("rst.out_valid", 32'(out_valid), 32'd0);
            chk("rst.out_sum",   32'(out_sum),   32'd0);
            chk("rst.out_count", 32'(out_count), 32'd0);
            chk("rst.ovf_trunc", 32'({out_ovf, out_trunc}), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_last   = 1'b0;
        rst_n     = 1'b1;
        step();
        chk("idle.in_ready",  32'(in_ready),  32'd1);
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // Basic burst 225 + 100 + 6 = 331.
        in_valid = 1'b1; in_prod = 8'd225; in_last = 1'b0; step();
        chk("basic.mid_valid", 32'(out_valid), 32'd0);
        in_prod = 8'd100; step();
        in_prod = 8'd6; in_last = 1'b1; step();
        chk_result("basic", 331, 3, 0, 0);
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk("basic.hold_ready", 32'(in_ready), 32'd0);
        handshake("basic");

        // Single-term burst, then backpressure for 10 cycles with in_valid high.
        in_valid = 1'b1; in_prod = 8'd10; in_last = 1'b1; step();
        chk_result("single", 10, 1, 0, 0);
        in_prod = 8'd200;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp.in_ready",  32'(in_ready),  32'd0);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.out_sum",   32'(out_sum),   32'd10);
            chk("bp.out_count", 32'(out_count), 32'd1);
        end
        handshake("bp");
        chk("bp.retain_sum", 32'(out_sum), 32'd10);

        // Toggling in_valid: 5, bubble, 7, bubble, 9(last) = 21.
        in_valid = 1'b1; in_prod = 8'd5;   in_last = 1'b0; step();
        in_valid = 1'b0; in_prod = 8'd99;  in_last = 1'b1; step();
        in_valid = 1'b1; in_prod = 8'd7;   in_last = 1'b0; step();
        in_valid = 1'b0; in_prod = 8'd250; in_last = 1'b1; step();
        chk("gap.mid_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_prod = 8'd9;   in_last = 1'b1; step();
        chk_result("gap", 21, 3, 0, 0);
        handshake("gap");

        // Saturation: 31 x 225 = 6975 -> 2879 mod 4096, carried out.
        in_valid = 1'b1; in_prod = 8'd225; in_last = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("sat.pre_valid", 32'(out_valid), 32'd0);
        chk("sat.pre_ready", 32'(in_ready),  32'd1);
        step();
        chk_result("sat", 2879, 31, 1, 1);
        handshake("sat");

        // in_last on exactly the 31st beat: not truncated.
        in_valid = 1'b1; in_prod = 8'd1; in_last = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("simul.pre_valid", 32'(out_valid), 32'd0);
        in_last = 1'b1; step();
        chk_result("simul", 31, 31, 0, 0);
        handshake("simul");

        // Mid-burst asynchronous reset after two beats.
        in_valid = 1'b1; in_prod = 8'd50; in_last = 1'b0; step();
        in_prod = 8'd60; step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.out_sum",   32'(out_sum),   32'd0);
        chk("mrst.out_count", 32'(out_count), 32'd0);
        chk("mrst.in_ready",  32'(in_ready),  32'd0);
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mrst.ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_prod = 8'd15; in_last = 1'b0; step();
        in_last = 1'b1; step();
        chk_result("post", 30, 2, 0, 0);
        handshake("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
